// File: rtl/secded_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Hamming SECDED decoder.
// Position helpers work on 1-based Hamming positions; bit i of a codeword is position i+1.
package secded_pkg;

  typedef enum logic [1:0] {
    ST_OK  = 2'b00,
    ST_SEC = 2'b01,
    ST_DED = 2'b10
  } status_t;

  // Smallest r with 2^r >= data_w + r + 1.
  function automatic int calc_par_w(input int data_w);
    int r;
    r = 1;
    for (int i = 0; i < 8; i++) begin
      if ((1 << r) < data_w + r + 1) r = r + 1;
    end
    return r;
  endfunction

  function automatic logic is_pow2(input int pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational Hamming syndrome and overall-parity computation for one codeword.
module secded_syndrome
  import secded_pkg::*;
#(
  parameter  int DATA_W = 4,
  localparam int PAR_W  = calc_par_w(DATA_W),
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic [CODE_W-1:0] code,
  output logic [PAR_W-1:0]  s,
  output logic              g
);

  // s[k] collects every bit whose Hamming position has bit k set; g0 has no position.
  always_comb begin
    s = '0;
    for (int k = 0; k < PAR_W; k++) begin
      for (int i = 0; i < CODE_W - 1; i++) begin
        if ((((i + 1) >> k) & 1) == 1) s[k] = s[k] ^ code[i];
      end
    end
  end

  assign g = ^code;

endmodule

// File: rtl/secded_decoder_pipe.sv
// Two-stage SECDED decoder: stage 1 holds code+syndrome, stage 2 holds the classified,
// optionally corrected data. Saturating SEC/DED counters count delivered words.
module secded_decoder_pipe
  import secded_pkg::*;
#(
  parameter  int DATA_W = 4,
  parameter  int CNT_W  = 16,
  localparam int PAR_W  = calc_par_w(DATA_W),
  localparam int CODE_W = DATA_W + PAR_W + 1,
  localparam int EP_W   = $clog2(CODE_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              correct_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PAR_W:0]    out_syndrome,
  output logic [1:0]        out_status,
  output logic [EP_W-1:0]   out_err_pos,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_single,
  output logic [CNT_W-1:0]  cnt_double
);

  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int i = 0; i < CODE_W - 1; i++) begin
      if (!is_pow2(i + 1) && j < DATA_W) begin
        d[j] = code[i];
        j = j + 1;
      end
    end
    return d;
  endfunction

  // Handshake: a stage advances when it is empty or its successor advances; a
  // transfer happens only on valid&ready, and a stalled stage holds its contents.
  logic s1_adv, s2_adv;
  logic v1, v2;

  assign s2_adv   = !v2 || out_ready;
  assign s1_adv   = !v1 || s2_adv;
  assign in_ready = s1_adv;
  assign out_valid = v2;

  logic [PAR_W-1:0] s_in;
  logic             g_in;

  secded_syndrome #(.DATA_W(DATA_W)) u_syndrome (
    .code (in_code),
    .s    (s_in),
    .g    (g_in)
  );

  logic [CODE_W-1:0] c1_q;
  logic [PAR_W-1:0]  s1_q;
  logic              g1_q;
  logic              ce1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      c1_q  <= '0;
      s1_q  <= '0;
      g1_q  <= 1'b0;
      ce1_q <= 1'b0;
    end else if (s1_adv) begin
      v1 <= in_valid;
      if (in_valid) begin
        c1_q  <= in_code;
        s1_q  <= s_in;
        g1_q  <= g_in;
        ce1_q <= correct_en;
      end
    end
  end

  status_t           st2;
  logic [EP_W-1:0]   pos2;
  logic [CODE_W-1:0] fixed2;
  logic [DATA_W-1:0] data2;

  // A nonzero syndrome beyond the last codeword position cannot be a single flip.
  always_comb begin
    st2    = ST_OK;
    pos2   = '0;
    fixed2 = c1_q;
    if (g1_q) begin
      if (s1_q == '0) begin
        st2  = ST_SEC;
        pos2 = EP_W'(CODE_W - 1);
      end else if (int'(s1_q) <= CODE_W - 1) begin
        st2  = ST_SEC;
        pos2 = EP_W'(int'(s1_q) - 1);
      end else begin
        st2 = ST_DED;
      end
    end else if (s1_q != '0) begin
      st2 = ST_DED;
    end
    if (ce1_q && st2 == ST_SEC) fixed2[pos2] = ~fixed2[pos2];
    data2 = extract_data(fixed2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2           <= 1'b0;
      out_data     <= '0;
      out_syndrome <= '0;
      out_status   <= ST_OK;
      out_err_pos  <= '0;
    end else if (s2_adv) begin
      v2 <= v1;
      if (v1) begin
        out_data     <= data2;
        out_syndrome <= {g1_q, s1_q};
        out_status   <= st2;
        out_err_pos  <= pos2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (cnt_clr) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (out_valid && out_ready) begin
      if (out_status == ST_SEC && cnt_single != '1) cnt_single <= cnt_single + 1'b1;
      if (out_status == ST_DED && cnt_double != '1) cnt_double <= cnt_double + 1'b1;
    end
  end

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Self-checking bench for secded_decoder_pipe (DATA_W=4) with a positional reference model.
module tb_secded_decoder_pipe;

  localparam int DATA_W = 4;
  localparam int PAR_W  = 3;
  localparam int CODE_W = 8;
  localparam int EP_W   = 3;
  localparam int EXP_W  = DATA_W + PAR_W + 1 + 2 + EP_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic              correct_en;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [PAR_W:0]    out_syndrome;
  logic [1:0]        out_status;
  logic [EP_W-1:0]   out_err_pos;
  logic              cnt_clr;
  logic [15:0]       cnt_single;
  logic [15:0]       cnt_double;

  logic              in_ready_b;
  logic              out_valid_b;
  logic [DATA_W-1:0] out_data_b;
  logic [PAR_W:0]    out_syndrome_b;
  logic [1:0]        out_status_b;
  logic [EP_W-1:0]   out_err_pos_b;
  logic [1:0]        cnt_single_b;
  logic [1:0]        cnt_double_b;

  secded_decoder_pipe #(.DATA_W(DATA_W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .correct_en(correct_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_syndrome(out_syndrome),
    .out_status(out_status), .out_err_pos(out_err_pos), .cnt_clr(cnt_clr),
    .cnt_single(cnt_single), .cnt_double(cnt_double)
  );

  // Narrow-counter copy fed identically; only its counters are of interest.
  secded_decoder_pipe #(.DATA_W(DATA_W), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_code(in_code), .correct_en(correct_en), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_syndrome(out_syndrome_b),
    .out_status(out_status_b), .out_err_pos(out_err_pos_b), .cnt_clr(cnt_clr),
    .cnt_single(cnt_single_b), .cnt_double(cnt_double_b)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int m_single = 0;
  int m_double = 0;
  logic [EXP_W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Syndrome = XOR of the positions of all set bits; data lives at non-power-of-two positions.
  function automatic logic [EXP_W-1:0] model(input logic [CODE_W-1:0] code, input logic ce);
    int s, g, pos, st;
    int dpos[4];
    logic [CODE_W-1:0] c;
    logic [DATA_W-1:0] d;
    logic [3:0] s4;
    dpos = '{2, 4, 5, 6};
    s = 0; g = 0; pos = 0;
    for (int i = 0; i < CODE_W - 1; i++) if (code[i]) s = s ^ (i + 1);
    for (int i = 0; i < CODE_W; i++) if (code[i]) g = g ^ 1;
    if (s == 0 && g == 0) st = 0;
    else if (g == 1 && s == 0) begin st = 1; pos = CODE_W - 1; end
    else if (g == 1 && s <= CODE_W - 1) begin st = 1; pos = s - 1; end
    else st = 2;
    c = code;
    if (ce && st == 1) c[pos] = ~c[pos];
    for (int j = 0; j < DATA_W; j++) d[j] = c[dpos[j]];
    s4 = 4'(s);
    return {d, g[0], s4[2:0], st[1:0], pos[2:0]};
  endfunction

  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    int s;
    c = '0;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    s = 0;
    for (int i = 0; i < CODE_W - 1; i++) if (c[i]) s = s ^ (i + 1);
    c[0] = s[0]; c[1] = s[1]; c[3] = s[2];
    c[7] = ^c[6:0];
    return c;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e, got;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_out++;
        checks++;
        got = {out_data, out_syndrome, out_status, out_err_pos};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got %h expected none", got);
        end else begin
          e = exp_q.pop_front();
          if (e[EP_W+1:EP_W] != 2'b01) got[EP_W-1:0] = e[EP_W-1:0];
          if (got !== e) begin
            errors++;
            $display("FAIL output_word got %h expected %h", got, e);
          end
          if (e[EP_W+1:EP_W] == 2'b01) m_single++;
          if (e[EP_W+1:EP_W] == 2'b10) m_double++;
        end
      end
      if (cnt_clr) begin
        m_single = 0;
        m_double = 0;
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_code, correct_en));
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [CODE_W-1:0] code, input logic ce);
    int n;
    n = 0;
    in_valid = 1'b1; in_code = code; correct_en = ce;
    @(negedge clk);
    while (!in_ready && n < 60) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (exp_q.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic check_counters(input string tag);
    int e16, e2;
    e16 = (m_single > 65535) ? 65535 : m_single;
    e2  = (m_single > 3) ? 3 : m_single;
    checks += 3;
    if (cnt_single !== 16'(e16)) begin errors++; $display("FAIL %s cnt_single got %0d expected %0d", tag, cnt_single, e16); end
    if (cnt_double !== 16'(m_double)) begin errors++; $display("FAIL %s cnt_double got %0d expected %0d", tag, cnt_double, m_double); end
    if (cnt_single_b !== 2'(e2)) begin errors++; $display("FAIL %s cnt_single_w2 got %0d expected %0d", tag, cnt_single_b, e2); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; correct_en = 1'b0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h expected 0", out_data); end
    if (out_syndrome !== '0) begin errors++; $display("FAIL reset_syndrome got %h expected 0", out_syndrome); end
    if (out_status !== 2'b00) begin errors++; $display("FAIL reset_status got %b expected 00", out_status); end
    if (out_err_pos !== '0) begin errors++; $display("FAIL reset_err_pos got %0d expected 0", out_err_pos); end
    if (cnt_single !== '0 || cnt_double !== '0) begin errors++; $display("FAIL reset_counters got %0d/%0d expected 0/0", cnt_single, cnt_double); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [7:0] codes[5] = '{8'h55, 8'h45, 8'h45, 8'hD5, 8'h44};
    logic       ces[5]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] datas[5] = '{4'b1011, 4'b1011, 4'b1001, 4'b1011, 4'b1001};
    logic [3:0] syns[5]  = '{4'b0000, 4'b1101, 4'b1101, 4'b1000, 4'b0100};
    logic [1:0] sts[5]   = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10};
    logic [2:0] poss[5]  = '{3'd0, 3'd4, 3'd4, 3'd7, 3'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(codes[i], ces[i]);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early[%0d] out_valid got %b expected 0", i, out_valid); end
      @(posedge clk); #1;
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL latency[%0d] out_valid got %b expected 1", i, out_valid); end
      if (out_data !== datas[i]) begin errors++; $display("FAIL dir_data[%0d] got %b expected %b", i, out_data, datas[i]); end
      if (out_syndrome !== syns[i]) begin errors++; $display("FAIL dir_syn[%0d] got %b expected %b", i, out_syndrome, syns[i]); end
      if (out_status !== sts[i]) begin errors++; $display("FAIL dir_status[%0d] got %b expected %b", i, out_status, sts[i]); end
      if (sts[i] == 2'b01) begin
        checks++;
        if (out_err_pos !== poss[i]) begin errors++; $display("FAIL dir_pos[%0d] got %0d expected %0d", i, out_err_pos, poss[i]); end
      end
    end
    drain();
    checks += 2;
    if (cnt_single !== 16'd3) begin errors++; $display("FAIL dir_cnt_single got %0d expected 3", cnt_single); end
    if (cnt_double !== 16'd1) begin errors++; $display("FAIL dir_cnt_double got %0d expected 1", cnt_double); end
  endtask

  task automatic test_backpressure();
    logic [EXP_W-1:0] held;
    int n, start;
    start = n_out;
    out_ready = 1'b0;
    send(8'h55, 1'b1);
    send(8'h45, 1'b1);
    in_valid = 1'b1; in_code = 8'h44; correct_en = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b expected 0", in_ready); end
    @(posedge clk); #1;
    held = {out_data, out_syndrome, out_status, out_err_pos};
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks += 2;
      if (!out_valid || {out_data, out_syndrome, out_status, out_err_pos} !== held) begin
        errors++;
        $display("FAIL bp_stable[%0d] got %h valid %b expected %h valid 1", c, {out_data, out_syndrome, out_status, out_err_pos}, out_valid, held);
      end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_hold[%0d] got %b expected 0", c, in_ready); end
    end
    out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    checks++;
    if (n_out - start != 3) begin errors++; $display("FAIL bp_delivered got %0d expected 3", n_out - start); end
    check_counters("bp");
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [CODE_W-1:0] c;
          int nflip, a, b;
          c = encode(4'($urandom_range(0, 15)));
          nflip = $urandom_range(0, 2);
          a = $urandom_range(0, CODE_W - 1);
          b = (a + $urandom_range(1, CODE_W - 1)) % CODE_W;
          if (nflip >= 1) c[a] = ~c[a];
          if (nflip == 2) c[b] = ~c[b];
          send(c, 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();
    check_counters("random");
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) send(8'h45, 1'b1);
    drain();
    checks += 2;
    if (cnt_single !== 16'd5) begin errors++; $display("FAIL sat_cnt16 got %0d expected 5", cnt_single); end
    if (cnt_single_b !== 2'd3) begin errors++; $display("FAIL sat_cnt2 got %0d expected 3", cnt_single_b); end
    check_counters("sat");
  endtask

  task automatic test_clr_collision();
    out_ready = 1'b1;
    send(8'h45, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_status !== 2'b01) begin errors++; $display("FAIL clr_setup got valid %b status %b expected 1 01", out_valid, out_status); end
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    checks += 2;
    if (cnt_single !== 16'd0) begin errors++; $display("FAIL clr_cnt16 got %0d expected 0", cnt_single); end
    if (cnt_single_b !== 2'd0) begin errors++; $display("FAIL clr_cnt2 got %0d expected 0", cnt_single_b); end
    drain();
  endtask

  task automatic test_reset_midstream();
    send(8'h44, 1'b1);
    drain();
    out_ready = 1'b0;
    send(8'h55, 1'b1);
    send(8'h45, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_single = 0;
    m_double = 0;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b expected 0", out_valid); end
    if (cnt_single !== '0 || cnt_double !== '0) begin errors++; $display("FAIL midrst_counters got %0d/%0d expected 0/0", cnt_single, cnt_double); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b expected 1", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_ghost[%0d] out_valid got %b expected 0", c, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_saturation();
    test_clr_collision();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/secded_decoder_pipe.md
Name: secded_decoder_pipe

Overview:
- Parametrised, pipelined Hamming SECDED decoder for received codewords of any data width.
- Computes the syndrome and classifies each word as no error, single corrected, or double/uncorrectable.
- Optionally corrects the word and extracts the data bits; keeps saturating error counters.
- Sits between the received-word source and downstream consumers, with valid/ready handshakes on both sides.

Parameters:
- DATA_W, 4, data bits per codeword; legal range 4..64.
- CNT_W, 16, width of each error counter.
- PAR_W (localparam), derived, smallest r with 2^r >= DATA_W+r+1 (3 for DATA_W=4).
- CODE_W (localparam), DATA_W+PAR_W+1, codeword width (8 for DATA_W=4).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_code valid.
- in_ready  out  1  decoder can accept a word.
- in_code  in  CODE_W  received codeword.
- correct_en  in  1  1 = correct, 0 = detect only; sampled with in_code.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_W  extracted data, corrected if enabled.
- out_syndrome  out  PAR_W+1  {g, s[PAR_W-1:0]}.
- out_status  out  2  classification (see package).
- out_err_pos  out  $clog2(CODE_W)  flipped bit index; meaningful only when out_status is SEC.
- cnt_clr  in  1  synchronous clear of both counters.
- cnt_single  out  CNT_W  count of SEC words delivered.
- cnt_double  out  CNT_W  count of DED words delivered.

Behaviour:
- Codeword layout:
  - Bit i (0..CODE_W-2) is Hamming position i+1.
  - Power-of-two positions are parity bits p0, p1, ...
  - Remaining positions hold data bits w0, w1, ... in ascending order.
  - Bit CODE_W-1 is the overall parity bit g0.
  - For DATA_W=4, layout from bit 7 down to bit 0: g0 w3 w2 w1 p2 w0 p1 p0.
- Syndrome:
  - s[k] = XOR of all bits whose position has bit k set.
  - g = XOR of all CODE_W bits; even parity means g = 0.
- Classification:
  - s=0, g=0 → OK.
  - g=1, s=0 → SEC, error in g0, err_pos = CODE_W-1.
  - g=1, 1 <= s <= CODE_W-1 → SEC, err_pos = s-1.
  - g=1, s > CODE_W-1 → DED (invalid position).
  - g=0, s≠0 → DED.
- Correction:
  - With correct_en=1 and SEC, invert bit err_pos before data extraction.
  - With correct_en=0, or on DED, extract the raw data bits.
  - Status and syndrome are always reported.
- Pipeline (two register stages):
  - Stage 1 registers the code, syndrome and correct_en.
  - Stage 2 registers data, syndrome, status and err_pos.
  - Latency is 2 cycles from the in handshake to out_valid when not stalled.
  - Full throughput of 1 word per cycle.
- Handshake:
  - s2_adv = !v2 | out_ready.
  - s1_adv = !v1 | s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no dependence on in_valid).
  - Transfers occur only on valid&ready.
  - While out_valid=1 and out_ready=0, all out_* fields stay stable.
  - With both stages full and stalled, in_ready=0.
- Counters:
  - Update on each out handshake: SEC increments cnt_single, DED increments cnt_double.
  - Each counter saturates at 2^CNT_W-1.
  - cnt_clr has priority over a simultaneous increment; the result is 0.
- Reset (asynchronous):
  - v1, v2, out_valid = 0.
  - out_data, out_syndrome, out_err_pos = 0.
  - out_status = OK.
  - Counters = 0.
  - in_ready = 1 after reset.
  - Words in flight when reset asserts are discarded.

Decomposition:
- Package secded_pkg holds:
  - typedef status_t: OK=2'b00, SEC=2'b01, DED=2'b10, 2'b11 reserved/never driven.
  - Function calc_par_w(DATA_W).
  - Function is_pow2(pos) for position mapping.
- Sub-module secded_syndrome:
  - Combinational, parametrised on DATA_W.
  - Input codeword; outputs s and g.
  - Instantiated in stage 1.

Test Plan:
- Clean word: DATA_W=4, in_code=8'h55, correct_en=1 → 2 cycles later out_data=4'b1011, out_syndrome=4'b0000, status OK, counters unchanged.
- Single data error: in_code=8'h45 (bit 4 flipped) → out_syndrome=4'b1101, status SEC, err_pos=4, out_data=4'b1011, cnt_single=1. Same word with correct_en=0 → out_data=4'b1001, status SEC.
- Overall parity error: in_code=8'hD5 → out_syndrome=4'b1000, status SEC, err_pos=7, out_data=4'b1011.
- Double error: in_code=8'h44 → out_syndrome=4'b0100, status DED, out_data=4'b1001 (raw), cnt_double=1.
- Backpressure: send 8'h55, 8'h45, 8'h44 back-to-back with out_ready=0 → in_ready falls after 2 accepts; first output held stable for 3 cycles. Then raise out_ready → words delivered in order, no loss or duplication, third word accepted.
- Counter/reset edges:
  - CNT_W=2, five SEC words → cnt_single=3.
  - cnt_clr in the same cycle as a SEC output → 0.
  - rst_n low mid-stream with 2 words in flight → out_valid=0 immediately, counters 0, and those words are never output after release.
